// File: rtl/fft_dit_pkg.sv
// Shared constants and types for the 8-point radix-2 DIT FFT pipeline.
// Optional round-half-up arithmetic is selected with FFT_DIT_ROUND_EN.
package fft_dit_pkg;

    localparam int FFT_SIZE = 8;
    localparam int IN_W     = 16;
    localparam int OUT_W    = 17;
    localparam int TW_W     = 16;
    localparam int STAGES   = 3;

    // W8^k = W8_COS[k] - j*W8_SIN[k], Q1.15
    localparam logic signed [TW_W-1:0] W8_COS [4] =
        '{16'sd32767, 16'sd23170, 16'sd0, -16'sd23170};
    localparam logic signed [TW_W-1:0] W8_SIN [4] =
        '{16'sd0, 16'sd23170, 16'sd32767, 16'sd23170};

    localparam int BIT_REV [FFT_SIZE] =
        '{0, 4, 2, 6, 1, 5, 3, 7};

    typedef struct packed {
        logic signed [OUT_W-1:0] re;
        logic signed [OUT_W-1:0] im;
    } cplx_t;

endpackage

// File: rtl/fft_dit_bfly.sv
// Combinational radix-2 butterfly: (a + b*W8^k)/2 and (a - b*W8^k)/2.
// FFT_DIT_ROUND_EN selects round-half-up; otherwise floor shifts.
module fft_dit_bfly
    import fft_dit_pkg::*;
(
    input  cplx_t      a_i,
    input  cplx_t      b_i,
    input  logic [1:0] tw_i,
    output cplx_t      p_o,
    output cplx_t      m_o
);

    localparam int BW = OUT_W + 1;
    localparam int PW = BW + TW_W;
    localparam int SW = OUT_W + 3;
    localparam int SH = TW_W - 1;

`ifdef FFT_DIT_ROUND_EN
    localparam int RND_TW = 1 << (SH - 1);
    localparam int RND_BF = 1;
`else
    localparam int RND_TW = 0;
    localparam int RND_BF = 0;
`endif

    logic signed [BW-1:0] sum_b, dif_b;
    logic signed [PW-1:0] prod_s, prod_d;
    logic signed [SW-1:0] tw_s, tw_d;
    logic signed [SW-1:0] t_re, t_im;
    logic signed [SW-1:0] p_re, p_im, m_re, m_im;

    // W^1 and W^3 share |cos| = |sin|, so one product per axis suffices
    assign sum_b  = BW'(b_i.re) + BW'(b_i.im);
    assign dif_b  = BW'(b_i.im) - BW'(b_i.re);
    assign prod_s = PW'(sum_b) * PW'(W8_COS[1]);
    assign prod_d = PW'(dif_b) * PW'(W8_SIN[1]);
    assign tw_s   = SW'((prod_s + PW'(RND_TW)) >>> SH);
    assign tw_d   = SW'((prod_d + PW'(RND_TW)) >>> SH);

    always_comb begin
        t_re = SW'(b_i.re);
        t_im = SW'(b_i.im);
        unique case (tw_i)
            2'd0: begin
                t_re = SW'(b_i.re);
                t_im = SW'(b_i.im);
            end
            2'd1: begin
                t_re = tw_s;
                t_im = tw_d;
            end
            2'd2: begin
                t_re = SW'(b_i.im);
                t_im = -SW'(b_i.re);
            end
            default: begin
                t_re = tw_d;
                t_im = -tw_s;
            end
        endcase
    end

    assign p_re = SW'(a_i.re) + t_re;
    assign p_im = SW'(a_i.im) + t_im;
    assign m_re = SW'(a_i.re) - t_re;
    assign m_im = SW'(a_i.im) - t_im;

    always_comb begin
        p_o.re = OUT_W'((p_re + SW'(RND_BF)) >>> 1);
        p_o.im = OUT_W'((p_im + SW'(RND_BF)) >>> 1);
        m_o.re = OUT_W'((m_re + SW'(RND_BF)) >>> 1);
        m_o.im = OUT_W'((m_im + SW'(RND_BF)) >>> 1);
    end

endmodule

// File: rtl/fft_dit_pipeline.sv
// Fully pipelined 8-point DIT FFT, one transform per clock, 1/8 scaled.
// Rounding mode set by FFT_DIT_ROUND_EN (see fft_dit_bfly).
module fft_dit_pipeline
    import fft_dit_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [IN_W-1:0]  x_r [FFT_SIZE],
    input  logic signed [IN_W-1:0]  x_i [FFT_SIZE],
    input  logic                    enable,
    output logic                    finish,
    output logic signed [OUT_W-1:0] y_r [FFT_SIZE],
    output logic signed [OUT_W-1:0] y_i [FFT_SIZE]
);

    localparam int NB = FFT_SIZE / 2;

    logic [STAGES:0] vld_q, vld_d;
    cplx_t s0_d [FFT_SIZE];
    cplx_t s0_q [FFT_SIZE];
    cplx_t s1_d [FFT_SIZE];
    cplx_t s1_q [FFT_SIZE];
    cplx_t s2_d [FFT_SIZE];
    cplx_t s2_q [FFT_SIZE];
    cplx_t s3_d [FFT_SIZE];
    cplx_t s3_q [FFT_SIZE];

    assign vld_d = {vld_q[STAGES-1:0], enable};

    for (genvar g = 0; g < FFT_SIZE; g++) begin : g_io
        // bit-reversed capture so every later stage is in-place
        assign s0_d[g].re = OUT_W'(x_r[BIT_REV[g]]);
        assign s0_d[g].im = OUT_W'(x_i[BIT_REV[g]]);
        assign y_r[g]     = s3_q[g].re;
        assign y_i[g]     = s3_q[g].im;
    end

    for (genvar g = 0; g < NB; g++) begin : g_bf
        localparam int A2 = 4 * (g / 2) + (g % 2);

        fft_dit_bfly u_s1 (
            .a_i (s0_q[2*g]),
            .b_i (s0_q[2*g+1]),
            .tw_i(2'd0),
            .p_o (s1_d[2*g]),
            .m_o (s1_d[2*g+1])
        );

        fft_dit_bfly u_s2 (
            .a_i (s1_q[A2]),
            .b_i (s1_q[A2+2]),
            .tw_i(2'(2 * (g % 2))),
            .p_o (s2_d[A2]),
            .m_o (s2_d[A2+2])
        );

        fft_dit_bfly u_s3 (
            .a_i (s2_q[g]),
            .b_i (s2_q[g+NB]),
            .tw_i(2'(g)),
            .p_o (s3_d[g]),
            .m_o (s3_d[g+NB])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            s0_q  <= '{default: '0};
            s1_q  <= '{default: '0};
            s2_q  <= '{default: '0};
            s3_q  <= '{default: '0};
        end else begin
            vld_q <= vld_d;
            if (enable)   s0_q <= s0_d;
            if (vld_q[0]) s1_q <= s1_d;
            if (vld_q[1]) s2_q <= s2_d;
            if (vld_q[2]) s3_q <= s3_d;
        end
    end

    assign finish = vld_q[STAGES];

endmodule

// File: tb/tb_fft_dit_pipeline.sv
// Directed and streaming bench for the 8-point DIT FFT pipeline.
// Tolerance follows FFT_DIT_ROUND_EN (1 LSB rounded, 3 LSB truncated).
module tb_fft_dit_pipeline;
    import fft_dit_pkg::*;

`ifdef FFT_DIT_ROUND_EN
    localparam int TOL = 1;
`else
    localparam int TOL = 3;
`endif
    localparam real PI = 3.14159265358979323846;
    localparam int NS = 10;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic finish;
    logic signed [IN_W-1:0]  x_r [FFT_SIZE];
    logic signed [IN_W-1:0]  x_i [FFT_SIZE];
    logic signed [OUT_W-1:0] y_r [FFT_SIZE];
    logic signed [OUT_W-1:0] y_i [FFT_SIZE];

    int n_cmp = 0;
    int n_err = 0;
    int st_r [NS][FFT_SIZE];
    int st_i [NS][FFT_SIZE];
    real ref_r [FFT_SIZE];
    real ref_i [FFT_SIZE];

    fft_dit_pipeline dut (
        .clk   (clk),
        .rst   (rst),
        .x_r   (x_r),
        .x_i   (x_i),
        .enable(enable),
        .finish(finish),
        .y_r   (y_r),
        .y_i   (y_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int r [FFT_SIZE], input int i [FFT_SIZE]);
        for (int n = 0; n < FFT_SIZE; n++) begin
            x_r[n] = 16'(r[n]);
            x_i[n] = 16'(i[n]);
        end
    endtask

    task automatic run_one(input int r [FFT_SIZE], input int i [FFT_SIZE]);
        drive(r, i);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        repeat (3) tick();
    endtask

    task automatic compute_ref(input int j);
        real ang;
        for (int k = 0; k < FFT_SIZE; k++) begin
            ref_r[k] = 0.0;
            ref_i[k] = 0.0;
            for (int n = 0; n < FFT_SIZE; n++) begin
                ang = -2.0 * PI * real'(n * k) / 8.0;
                ref_r[k] += real'(st_r[j][n]) * $cos(ang)
                          - real'(st_i[j][n]) * $sin(ang);
                ref_i[k] += real'(st_r[j][n]) * $sin(ang)
                          + real'(st_i[j][n]) * $cos(ang);
            end
            ref_r[k] = ref_r[k] / 8.0;
            ref_i[k] = ref_i[k] / 8.0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b0;
        for (int n = 0; n < FFT_SIZE; n++) begin
            x_r[n] = '0;
            x_i[n] = '0;
        end
        repeat (2) tick();
        n_cmp++;
        if (finish !== 1'b0) begin
            n_err++;
            $display("FAIL reset finish: got %b want 0", finish);
        end
        for (int k = 0; k < FFT_SIZE; k++) begin
            n_cmp++;
            if (y_r[k] !== '0 || y_i[k] !== '0) begin
                n_err++;
                $display("FAIL reset y[%0d]: got %0d,%0d want 0,0",
                         k, y_r[k], y_i[k]);
            end
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_impulse();
        int r [FFT_SIZE] = '{16384, 0, 0, 0, 0, 0, 0, 0};
        int z [FFT_SIZE] = '{default: 0};
        drive(r, z);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        for (int e = 0; e <= 3; e++) begin
            if (e > 0) tick();
            n_cmp++;
            if (finish !== (e == 3)) begin
                n_err++;
                $display("FAIL impulse finish edge+%0d: got %b want %b",
                         e, finish, (e == 3));
            end
        end
        for (int k = 0; k < FFT_SIZE; k++) begin
            n_cmp++;
            if (y_r[k] !== 17'sd2048 || y_i[k] !== 17'sd0) begin
                n_err++;
                $display("FAIL impulse y[%0d]: got %0d,%0d want 2048,0",
                         k, y_r[k], y_i[k]);
            end
        end
        tick();
        n_cmp++;
        if (finish !== 1'b0 || y_r[3] !== 17'sd2048) begin
            n_err++;
            $display("FAIL impulse hold: got fin=%b y_r3=%0d want 0,2048",
                     finish, y_r[3]);
        end
    endtask

    task automatic test_dc();
        int r [FFT_SIZE] = '{default: 8192};
        int z [FFT_SIZE] = '{default: 0};
        int er [FFT_SIZE] = '{8192, 0, 0, 0, 0, 0, 0, 0};
        int dr, di;
        run_one(r, z);
        n_cmp++;
        if (finish !== 1'b1) begin
            n_err++;
            $display("FAIL dc finish: got %b want 1", finish);
        end
        for (int k = 0; k < FFT_SIZE; k++) begin
            dr = int'(y_r[k]) - er[k];
            di = int'(y_i[k]);
            n_cmp++;
            if ($isunknown({y_r[k], y_i[k]}) || dr > TOL || dr < -TOL
                || di > TOL || di < -TOL) begin
                n_err++;
                $display("FAIL dc y[%0d]: got %0d,%0d want %0d,0",
                         k, y_r[k], y_i[k], er[k]);
            end
        end
    endtask

    task automatic test_nyquist();
        int r [FFT_SIZE] = '{8192, -8192, 8192, -8192,
                             8192, -8192, 8192, -8192};
        int z [FFT_SIZE] = '{default: 0};
        int er [FFT_SIZE] = '{0, 0, 0, 0, 8192, 0, 0, 0};
        int dr, di;
        run_one(r, z);
        n_cmp++;
        if (finish !== 1'b1) begin
            n_err++;
            $display("FAIL nyquist finish: got %b want 1", finish);
        end
        for (int k = 0; k < FFT_SIZE; k++) begin
            dr = int'(y_r[k]) - er[k];
            di = int'(y_i[k]);
            n_cmp++;
            if ($isunknown({y_r[k], y_i[k]}) || dr > TOL || dr < -TOL
                || di > TOL || di < -TOL) begin
                n_err++;
                $display("FAIL nyquist y[%0d]: got %0d,%0d want %0d,0",
                         k, y_r[k], y_i[k], er[k]);
            end
        end
    endtask

    task automatic test_tone();
        int r [FFT_SIZE] = '{16384, 11585, 0, -11585,
                             -16384, -11585, 0, 11585};
        int i [FFT_SIZE] = '{0, 11585, 16384, 11585,
                             0, -11585, -16384, -11585};
        int er [FFT_SIZE] = '{0, 16384, 0, 0, 0, 0, 0, 0};
        int dr, di;
        run_one(r, i);
        n_cmp++;
        if (finish !== 1'b1) begin
            n_err++;
            $display("FAIL tone finish: got %b want 1", finish);
        end
        for (int k = 0; k < FFT_SIZE; k++) begin
            dr = int'(y_r[k]) - er[k];
            di = int'(y_i[k]);
            n_cmp++;
            if ($isunknown({y_r[k], y_i[k]}) || dr > TOL || dr < -TOL
                || di > TOL || di < -TOL) begin
                n_err++;
                $display("FAIL tone y[%0d]: got %0d,%0d want %0d,0",
                         k, y_r[k], y_i[k], er[k]);
            end
        end
    endtask

    task automatic test_streaming();
        real d;
        bit exp_fin;
        for (int j = 0; j < NS; j++) begin
            for (int n = 0; n < FFT_SIZE; n++) begin
                st_r[j][n] = int'($urandom_range(0, 60000)) - 30000;
                st_i[j][n] = int'($urandom_range(0, 60000)) - 30000;
            end
        end
        for (int c = 0; c < NS + 4; c++) begin
            if (c < NS) begin
                for (int n = 0; n < FFT_SIZE; n++) begin
                    x_r[n] = 16'(st_r[c][n]);
                    x_i[n] = 16'(st_i[c][n]);
                end
                enable = 1'b1;
            end else begin
                enable = 1'b0;
            end
            tick();
            exp_fin = (c >= 3) && (c < NS + 3);
            n_cmp++;
            if (finish !== exp_fin) begin
                n_err++;
                $display("FAIL stream finish c%0d: got %b want %b",
                         c, finish, exp_fin);
            end
            if (exp_fin) begin
                compute_ref(c - 3);
                for (int k = 0; k < FFT_SIZE; k++) begin
                    n_cmp++;
                    d = real'(int'(y_r[k])) - ref_r[k];
                    if ($isunknown(y_r[k]) || d > TOL || d < -TOL) begin
                        n_err++;
                        $display("FAIL stream%0d y_r[%0d]: got %0d want %f",
                                 c - 3, k, y_r[k], ref_r[k]);
                    end
                    n_cmp++;
                    d = real'(int'(y_i[k])) - ref_i[k];
                    if ($isunknown(y_i[k]) || d > TOL || d < -TOL) begin
                        n_err++;
                        $display("FAIL stream%0d y_i[%0d]: got %0d want %f",
                                 c - 3, k, y_i[k], ref_i[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        int r [FFT_SIZE] = '{16384, 0, 0, 0, 0, 0, 0, 0};
        int z [FFT_SIZE] = '{default: 0};
        for (int c = 0; c < 3; c++) begin
            for (int n = 0; n < FFT_SIZE; n++) begin
                x_r[n] = 16'(st_r[c][n]);
                x_i[n] = 16'(st_i[c][n]);
            end
            enable = 1'b1;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        enable = 1'b0;
        n_cmp++;
        if (finish !== 1'b0) begin
            n_err++;
            $display("FAIL midrst finish: got %b want 0", finish);
        end
        for (int k = 0; k < FFT_SIZE; k++) begin
            n_cmp++;
            if (y_r[k] !== '0 || y_i[k] !== '0) begin
                n_err++;
                $display("FAIL midrst y[%0d]: got %0d,%0d want 0,0",
                         k, y_r[k], y_i[k]);
            end
        end
        for (int e = 0; e < 4; e++) begin
            tick();
            n_cmp++;
            if (finish !== 1'b0) begin
                n_err++;
                $display("FAIL midrst drain e%0d: got %b want 0", e, finish);
            end
        end
        run_one(r, z);
        n_cmp++;
        if (finish !== 1'b1) begin
            n_err++;
            $display("FAIL midrst next finish: got %b want 1", finish);
        end
        for (int k = 0; k < FFT_SIZE; k++) begin
            n_cmp++;
            if (y_r[k] !== 17'sd2048 || y_i[k] !== 17'sd0) begin
                n_err++;
                $display("FAIL midrst next y[%0d]: got %0d,%0d want 2048,0",
                         k, y_r[k], y_i[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_dc();
        test_nyquist();
        test_tone();
        test_streaming();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
